instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/npc_pkg.sv | 14 +
 rtl/instr_fetch_if.sv | 28 ++
 rtl/fetch_buf.sv | 53 +++++
 rtl/instr_fetch.sv | 152 +++++++++++++++
 tb/tb_instr_fetch.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/npc_pkg.sv
// Shared types and constants for the instruction fetch unit.
package npc_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam int unsigned INSTR_BYTES      = 4;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: redirect input, memory request/response and decoder handshake.
interface instr_fetch_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  mem_req_valid;
    logic [DATA_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_ready;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_data;
    logic                  instr_valid;
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] instr_pc;
    logic                  instr_ready;
    logic                  fetch_fault;

    modport master (
        input  redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
        output mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc, fetch_fault
    );

    modport slave (
        output redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
        input  mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc, fetch_fault
    );

endinterface

// File: rtl/fetch_buf.sv
// One-entry output register holding the instruction offered to the decoder.
// Flush wins over load, load wins over consume.
module fetch_buf #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  consume,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] load_instr,
    input  logic [DATA_WIDTH-1:0] load_pc,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] pc
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = load_instr;
            pc_d    = load_pc;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: single outstanding request, redirect with response drop, one-entry output buffer.
// FETCH_MISALIGN_CHECK_EN enables the sticky misaligned-redirect fault; otherwise redirect_pc[1:0] is ignored.
//   state    | meaning
//   ST_REQ   | request at pc driven on the memory bus
//   ST_WAIT  | request accepted, waiting for its response (drop_q marks it stale)
//   ST_HOLD  | instruction offered to the decoder
//   ST_FAULT | misaligned redirect seen, stalled until reset
module instr_fetch
    import npc_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
    input logic           clk,
    input logic           rst,
    instr_fetch_if.master bus
);

    fetch_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  drop_q, drop_d;
    logic [DATA_WIDTH-1:0] redir_pc;
    logic                  fault_set;
    logic                  buf_load;
    logic                  buf_flush;
    logic                  buf_consume;
    logic                  buf_valid;
    logic [DATA_WIDTH-1:0] buf_instr;
    logic [DATA_WIDTH-1:0] buf_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q, fault_d;

    assign redir_pc  = bus.redirect_pc;
    assign fault_set = bus.redirect_valid && (state_q != ST_FAULT) && (bus.redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign bus.fetch_fault = fault_q;
`else
    logic unused_redirect_lsbs;

    assign redir_pc             = {bus.redirect_pc[DATA_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];
    assign fault_set            = 1'b0;
    assign bus.fetch_fault      = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        buf_load  = 1'b0;
        buf_flush = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        fault_d   = fault_q | fault_set;
`endif
        unique case (state_q)
            ST_REQ: begin
                if (bus.redirect_valid) begin
                    pc_d = redir_pc;
                end
                // A request accepted under a redirect still goes out; its response is marked stale.
                if (bus.mem_req_ready) begin
                    state_d = ST_WAIT;
                    drop_d  = bus.redirect_valid;
                end
            end
            ST_WAIT: begin
                if (bus.redirect_valid) begin
                    pc_d = redir_pc;
                    if (bus.mem_rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (bus.mem_rsp_valid) begin
                    drop_d = 1'b0;
                    if (drop_q) begin
                        state_d = ST_REQ;
                    end else begin
                        buf_load = 1'b1;
                        pc_d     = pc_q + DATA_WIDTH'(INSTR_BYTES);
                        state_d  = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.redirect_valid) begin
                    pc_d      = redir_pc;
                    buf_flush = 1'b1;
                    state_d   = ST_REQ;
                end else if (bus.instr_ready) begin
                    state_d = ST_REQ;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
        endcase
        if (fault_set) begin
            state_d   = ST_FAULT;
            pc_d      = pc_q;
            drop_d    = 1'b0;
            buf_load  = 1'b0;
            buf_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    assign buf_consume = bus.instr_ready & buf_valid;

    fetch_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fetch_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .consume   (buf_consume),
        .flush     (buf_flush),
        .load_instr(bus.mem_rsp_data),
        .load_pc   (pc_q),
        .valid     (buf_valid),
        .instr     (buf_instr),
        .pc        (buf_pc)
    );

    assign bus.mem_req_valid = (state_q == ST_REQ);
    assign bus.mem_req_addr  = pc_q;
    assign bus.instr_valid   = buf_valid;
    assign bus.instr         = buf_instr;
    assign bus.instr_pc      = buf_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: memory model answers addr ^ 32'h1357_9BDF, monitor checks handshakes.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    int          n_vec = 0;
    int          n_err = 0;
    int          mem_wait = 0;
    logic [31:0] mem_addr;
    logic [63:0] exp_ins;
    logic [31:0] exp_req_q[$];
    logic [63:0] exp_instr_q[$];

    instr_fetch_if #(.DATA_WIDTH(32)) bus ();

    instr_fetch #(
        .DATA_WIDTH(32),
        .RESET_PC  (32'h8000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // memory: accepts at the edge, answers mem_wait cycles after the cycle following acceptance
    initial begin
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && bus.mem_req_valid && bus.mem_req_ready) begin
                mem_addr = bus.mem_req_addr;
                @(posedge clk);
                repeat (mem_wait) @(posedge clk);
                #1;
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = mem_addr ^ 32'h1357_9BDF;
                @(posedge clk);
                #1;
                bus.mem_rsp_valid = 1'b0;
            end
        end
    end

    // monitor: pops the scoreboard on every accepted request and every decoder consume
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (bus.mem_req_valid && bus.mem_req_ready) begin
                    if (exp_req_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL req_unexpected: got 0x%08h, want no request", bus.mem_req_addr);
                    end else begin
                        chk("req_addr", bus.mem_req_addr, exp_req_q.pop_front());
                    end
                end
                if (bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
                    if (exp_instr_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL consume_unexpected: got pc 0x%08h, want no consume", bus.instr_pc);
                    end else begin
                        exp_ins = exp_instr_q.pop_front();
                        chk("consume_instr", bus.instr, exp_ins[63:32]);
                        chk("consume_pc", bus.instr_pc, exp_ins[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, want completion");
        $fatal(1, "watchdog expired");
    end

    // redirect in REQ with ready=1 (drop), then fetch at 0xFFFF_FFFC and wrap to 0
    task automatic wrap_tail(input logic [31:0] x);
        exp_req_q.push_back(x);
        chk("drop_req_valid", bus.mem_req_valid, 1);
        chk("drop_req_addr", bus.mem_req_addr, x);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        exp_req_q.push_back(32'hFFFF_FFFC);
        chk("drop_wait_no_req", bus.mem_req_valid, 0);
        step();
        chk("drop_no_instr", bus.instr_valid, 0);
        chk("wrap_req_valid", bus.mem_req_valid, 1);
        chk("wrap_req_addr", bus.mem_req_addr, 32'hFFFF_FFFC);
        step();
        step();
        chk("wrap_instr_valid", bus.instr_valid, 1);
        chk("wrap_instr_pc", bus.instr_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", bus.instr, 32'hECA8_6423);
        exp_instr_q.push_back({32'hECA8_6423, 32'hFFFF_FFFC});
        exp_req_q.push_back(32'h0000_0000);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        chk("zero_req_valid", bus.mem_req_valid, 1);
        chk("zero_req_addr", bus.mem_req_addr, 32'h0000_0000);
        step();
        bus.mem_req_ready = 1'b0;
        step();
        chk("zero_instr_valid", bus.instr_valid, 1);
        chk("zero_instr_pc", bus.instr_pc, 32'h0000_0000);
        chk("zero_instr", bus.instr, 32'h1357_9BDF);
    endtask

    initial begin
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.mem_req_ready  = 1'b0;
        bus.instr_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_instr_valid", bus.instr_valid, 0);
        chk("rst_instr", bus.instr, 0);
        chk("rst_instr_pc", bus.instr_pc, 0);
        chk("rst_fetch_fault", bus.fetch_fault, 0);

        // cycle 1 after release: request at reset pc, zero-wait memory
        exp_req_q.push_back(32'h8000_0000);
        rst               = 1'b0;
        bus.mem_req_ready = 1'b1;
        chk("c1_req_valid", bus.mem_req_valid, 1);
        chk("c1_req_addr", bus.mem_req_addr, 32'h8000_0000);
        step();
        chk("c2_instr_valid", bus.instr_valid, 0);
        chk("c2_no_req", bus.mem_req_valid, 0);
        step();
        chk("c3_instr_valid", bus.instr_valid, 1);
        chk("c3_instr_pc", bus.instr_pc, 32'h8000_0000);
        chk("c3_instr", bus.instr, 32'h9357_9BDF);

        // decoder stalls 5 cycles in HOLD
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", bus.instr_valid, 1);
            chk("hold_instr", bus.instr, 32'h9357_9BDF);
            chk("hold_pc", bus.instr_pc, 32'h8000_0000);
            chk("hold_no_req", bus.mem_req_valid, 0);
            step();
        end
        exp_instr_q.push_back({32'h9357_9BDF, 32'h8000_0000});
        exp_req_q.push_back(32'h8000_0004);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        chk("seq_req_valid", bus.mem_req_valid, 1);
        chk("seq_req_addr", bus.mem_req_addr, 32'h8000_0004);
        step();
        step();
        chk("seq_instr_valid", bus.instr_valid, 1);
        chk("seq_instr_pc", bus.instr_pc, 32'h8000_0004);
        chk("seq_instr", bus.instr, 32'h9357_9BDB);
        exp_instr_q.push_back({32'h9357_9BDB, 32'h8000_0004});
        exp_req_q.push_back(32'h8000_0008);
        bus.instr_ready = 1'b1;
        mem_wait        = 3;
        step();
        bus.instr_ready = 1'b0;
        chk("wait_req_addr", bus.mem_req_addr, 32'h8000_0008);

        // redirect while waiting; the late response must be dropped
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0100;
        step();
        bus.redirect_valid = 1'b0;
        exp_req_q.push_back(32'h8000_0100);
        for (int i = 0; i < 3; i++) begin
            chk("wait_no_req", bus.mem_req_valid, 0);
            chk("wait_no_instr", bus.instr_valid, 0);
            step();
        end
        chk("redir_no_instr", bus.instr_valid, 0);
        chk("redir_req_valid", bus.mem_req_valid, 1);
        chk("redir_req_addr", bus.mem_req_addr, 32'h8000_0100);
        mem_wait = 0;
        step();
        step();
        chk("redir_instr_pc", bus.instr_pc, 32'h8000_0100);
        chk("redir_instr", bus.instr, 32'h9357_9ADF);

        // redirect in HOLD coincident with instr_ready: no consume
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0200;
        bus.instr_ready    = 1'b1;
        exp_req_q.push_back(32'h8000_0200);
        step();
        bus.redirect_valid = 1'b0;
        bus.instr_ready    = 1'b0;
        chk("hredir_instr_valid", bus.instr_valid, 0);
        chk("hredir_req_valid", bus.mem_req_valid, 1);
        chk("hredir_req_addr", bus.mem_req_addr, 32'h8000_0200);
        step();
        step();
        chk("hredir_instr_pc", bus.instr_pc, 32'h8000_0200);
        chk("hredir_instr", bus.instr, 32'h9357_99DF);
        exp_instr_q.push_back({32'h9357_99DF, 32'h8000_0200});
        bus.instr_ready   = 1'b1;
        bus.mem_req_ready = 1'b0;
        step();
        bus.instr_ready = 1'b0;
        chk("stall_req_valid", bus.mem_req_valid, 1);
        chk("stall_req_addr", bus.mem_req_addr, 32'h8000_0204);

        // misaligned redirect while the request is not accepted
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0102;
        step();
`ifdef FETCH_MISALIGN_CHECK_EN
        bus.redirect_pc   = 32'h8000_0300;
        bus.mem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("fault_flag", bus.fetch_fault, 1);
            chk("fault_no_req", bus.mem_req_valid, 0);
            chk("fault_no_instr", bus.instr_valid, 0);
            step();
        end
        bus.redirect_valid = 1'b0;
        bus.mem_req_ready  = 1'b0;
        rst                = 1'b1;
        #1;
        chk("fault_rst_flag", bus.fetch_fault, 0);
        chk("fault_rst_instr", bus.instr_valid, 0);
        step();
        rst               = 1'b0;
        bus.mem_req_ready = 1'b1;
        wrap_tail(32'h8000_0000);
`else
        bus.redirect_valid = 1'b0;
        chk("align_no_fault", bus.fetch_fault, 0);
        chk("align_req_valid", bus.mem_req_valid, 1);
        chk("align_req_addr", bus.mem_req_addr, 32'h8000_0100);
        exp_req_q.push_back(32'h8000_0100);
        bus.mem_req_ready = 1'b1;
        step();
        step();
        chk("align_instr_pc", bus.instr_pc, 32'h8000_0100);
        chk("align_instr", bus.instr, 32'h9357_9ADF);
        exp_instr_q.push_back({32'h9357_9ADF, 32'h8000_0100});
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        wrap_tail(32'h8000_0104);
`endif

        step();
        step();
        chk("req_queue_drained", 32'(exp_req_q.size()), 0);
        chk("instr_queue_drained", 32'(exp_instr_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
